// File: rtl/des_stream_sequencer_pkg.sv
// Shared types and constants for the DES stream sequencer and its wrapper link.
package des_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LD_KEY_LO,
    LD_KEY_HI,
    LD_DAT_LO,
    LD_DAT_HI,
    START,
    WAIT,
    RD_HI,
    RD_LO,
    OUT
  } des_seq_state_t;

  localparam logic [1:0] SEL_KEY_LO = 2'b00;
  localparam logic [1:0] SEL_KEY_HI = 2'b01;
  localparam logic [1:0] SEL_DAT_LO = 2'b10;
  localparam logic [1:0] SEL_DAT_HI = 2'b11;

  localparam int DES_WRAP_DELAY = 3;

endpackage

// File: rtl/des_stream_sequencer_if.sv
// Host-side block/result streams of the DES sequencer.
// A beat moves on the rising edge where valid and ready are both high; valid,
// once raised, stays high with stable data until that edge.
interface des_stream_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/des_stream_sequencer.sv
// Host-side sequencer: loads key/block words into des_top_wrapper, pulses start,
// waits for ready, reads both result halves and streams the 64-bit result out.
module des_stream_sequencer
  import des_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [63:0]            key_in,
  input  logic                   key_load,
  des_stream_sequencer_if.slave  host,
  output logic                   busy,
  output logic                   err_timeout,
  output logic [31:0]            des_data_bus,
  output logic [1:0]             des_selector,
  output logic                   des_load,
  output logic                   des_start,
  output logic                   des_result_sel,
  input  logic [31:0]            des_result_out,
  input  logic                   des_ready,
  output des_seq_state_t         dbg_state
);

  localparam int            CW          = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TIMEOUT_VAL = CW'(TIMEOUT_CYCLES);

  des_seq_state_t r_state, w_state_nxt;
  logic [63:0]    r_key_shadow, r_block, r_out;
  logic           r_key_pending, r_key_lo_hit, r_err;
  logic [CW-1:0]  r_cnt;
  logic [31:0]    r_bus;
  logic [1:0]     r_sel;
  logic           r_load, r_start, r_result_sel;

  logic           w_accept, w_timeout, w_load;
  logic [63:0]    w_shadow_nxt, w_block_nxt;
  logic [CW-1:0]  w_cnt_inc;
  logic [31:0]    w_bus;
  logic [1:0]     w_sel;

  assign w_accept     = (r_state == IDLE) && host.in_valid;
  assign w_shadow_nxt = key_load ? key_in : r_key_shadow;
  assign w_block_nxt  = w_accept ? host.in_data : r_block;
  assign w_cnt_inc    = r_cnt + CW'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    case (r_state)
      IDLE:      if (host.in_valid)
                   w_state_nxt = (r_key_pending || key_load) ? LD_KEY_LO : LD_DAT_LO;
      LD_KEY_LO: w_state_nxt = LD_KEY_HI;
      LD_KEY_HI: w_state_nxt = LD_DAT_LO;
      LD_DAT_LO: w_state_nxt = LD_DAT_HI;
      LD_DAT_HI: w_state_nxt = START;
      START:     w_state_nxt = WAIT;
      WAIT: begin
        if (des_ready) begin
          w_state_nxt = RD_HI;
        end else if (w_cnt_inc == TIMEOUT_VAL) begin
          w_state_nxt = IDLE;
          w_timeout   = 1'b1;
        end
      end
      RD_HI:     w_state_nxt = RD_LO;
      RD_LO:     w_state_nxt = OUT;
      OUT:       if (host.out_ready) w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
  end

  // Wrapper-side outputs are registered, so they are decoded from the next state
  // and from the values the shadow/block registers take on the same edge.
  always_comb begin
    w_load = 1'b0;
    w_sel  = SEL_KEY_LO;
    w_bus  = '0;
    case (w_state_nxt)
      LD_KEY_LO: begin w_load = 1'b1; w_sel = SEL_KEY_LO; w_bus = w_shadow_nxt[31:0];  end
      LD_KEY_HI: begin w_load = 1'b1; w_sel = SEL_KEY_HI; w_bus = w_shadow_nxt[63:32]; end
      LD_DAT_LO: begin w_load = 1'b1; w_sel = SEL_DAT_LO; w_bus = w_block_nxt[31:0];   end
      LD_DAT_HI: begin w_load = 1'b1; w_sel = SEL_DAT_HI; w_bus = w_block_nxt[63:32];  end
      default:   ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_key_shadow  <= '0;
      r_block       <= '0;
      r_out         <= '0;
      r_key_pending <= 1'b0;
      r_key_lo_hit  <= 1'b0;
      r_err         <= 1'b0;
      r_cnt         <= '0;
      r_bus         <= '0;
      r_sel         <= SEL_KEY_LO;
      r_load        <= 1'b0;
      r_start       <= 1'b0;
      r_result_sel  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) r_block <= host.in_data;
      if (key_load) r_key_shadow <= key_in;
      // A key written while its halves are going out leaves a torn copy in the
      // wrapper, so the reload stays pending for the next block.
      r_key_lo_hit <= (r_state == LD_KEY_LO) && key_load;
      if (r_state == LD_KEY_HI) r_key_pending <= key_load || r_key_lo_hit;
      else if (key_load)        r_key_pending <= 1'b1;
      if (r_state == START)                    r_cnt <= '0;
      else if (r_state == WAIT && !des_ready)  r_cnt <= w_cnt_inc;
      if (w_timeout) r_err <= 1'b1;
      r_load       <= w_load;
      r_sel        <= w_sel;
      r_bus        <= w_bus;
      r_start      <= (w_state_nxt == START);
      r_result_sel <= (w_state_nxt == RD_LO);
      if (r_state == RD_HI) r_out[63:32] <= des_result_out;
      if (r_state == RD_LO) r_out[31:0]  <= des_result_out;
    end
  end

  assign host.in_ready  = (r_state == IDLE) && !rst;
  assign host.out_valid = (r_state == OUT);
  assign host.out_data  = r_out;
  assign busy           = (r_state != IDLE);
  assign err_timeout    = r_err;
  assign des_data_bus   = r_bus;
  assign des_selector   = r_sel;
  assign des_load       = r_load;
  assign des_start      = r_start;
  assign des_result_sel = r_result_sel;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_des_stream_sequencer.sv
// Bench for des_stream_sequencer with a behavioural stand-in for des_top_wrapper
// (fixed ready delay, word-addressed key/data registers, keyed result function).
module tb_des_stream_sequencer;
  import des_pkg::*;

  localparam logic [63:0] K1 = 64'h1334_5779_9BBC_DFF1;
  localparam logic [63:0] P1 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] C1 = 64'h85E8_1354_0F0A_B405;

  logic           clk;
  logic           rst;
  logic [63:0]    key_in;
  logic           key_load;
  logic           busy, err_timeout;
  logic [31:0]    des_data_bus, des_result_out;
  logic [1:0]     des_selector;
  logic           des_load, des_start, des_result_sel, des_ready;
  des_seq_state_t dut_state;

  des_stream_sequencer_if hs();

  des_stream_sequencer #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_load(key_load), .host(hs),
    .busy(busy), .err_timeout(err_timeout), .des_data_bus(des_data_bus),
    .des_selector(des_selector), .des_load(des_load), .des_start(des_start),
    .des_result_sel(des_result_sel), .des_result_out(des_result_out),
    .des_ready(des_ready), .dbg_state(dut_state)
  );

  // clock / reset-independent infrastructure
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, run did not finish");
    $fatal(1);
  end

  // Known-answer pair returns the real DES result; other pairs use a keyed mix.
  function automatic logic [63:0] des_ref(input logic [63:0] k, input logic [63:0] d);
    if (k == K1 && d == P1) return C1;
    return {d[31:0], d[63:32]} ^ {k[15:0], k[63:16]} ^ 64'hA5A5_0F0F_5A5A_F0F0;
  endfunction

  // wrapper stand-in
  logic [63:0] w_key, w_dat, w_res;
  int          w_cnt;
  logic        w_rdy;
  bit          stub_stuck;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      w_key <= '0; w_dat <= '0; w_res <= '0; w_cnt <= 0; w_rdy <= 1'b0;
    end else begin
      if (des_load) begin
        case (des_selector)
          SEL_KEY_LO: w_key[31:0]  <= des_data_bus;
          SEL_KEY_HI: w_key[63:32] <= des_data_bus;
          SEL_DAT_LO: w_dat[31:0]  <= des_data_bus;
          default:    w_dat[63:32] <= des_data_bus;
        endcase
      end
      if (des_start) begin
        w_rdy <= 1'b0;
        w_cnt <= DES_WRAP_DELAY;
        w_res <= des_ref(w_key, w_dat);
      end else if (w_cnt != 0) begin
        w_cnt <= w_cnt - 1;
        if (w_cnt == 1) w_rdy <= 1'b1;
      end
    end
  end

  assign des_ready      = w_rdy && !stub_stuck;
  assign des_result_out = des_result_sel ? w_res[31:0] : w_res[63:32];

  // out_ready driver: 0 = held high, 1 = held low, 2 = random
  int rdy_mode = 0;
  initial begin
    hs.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       hs.out_ready = 1'b1;
        1:       hs.out_ready = 1'b0;
        default: hs.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // output / load-bus monitor
  logic [63:0] obs_data[$];
  int          key_beats_tot = 0, dat_beats_tot = 0, stall_viol = 0, stall_cycles = 0;
  logic [63:0] prev_data = '0;
  bit          prev_stall = 1'b0;

  always @(negedge clk) begin
    if (des_load) begin
      if (des_selector[1]) dat_beats_tot++;
      else                 key_beats_tot++;
    end
    if (prev_stall && (hs.out_data !== prev_data || !hs.out_valid)) stall_viol++;
    if (hs.out_valid && !hs.out_ready) stall_cycles++;
    if (hs.out_valid && hs.out_ready) obs_data.push_back(hs.out_data);
    prev_stall = hs.out_valid && !hs.out_ready && !rst;
    prev_data  = hs.out_data;
  end

  // scoreboard and checking
  logic [63:0] exp_q[$];
  int          n_total = 0, n_bad = 0;
  int          n_pushed = 0, rd_idx = 0;
  int          snap_k = 0, snap_d = 0;
  logic [63:0] model_key = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic send_block(input logic [63:0] data, input bit kl,
                            input logic [63:0] key, input bit expect_out);
    int g = 0;
    @(negedge clk);
    while (!hs.in_ready && g < 200) begin @(negedge clk); g++; end
    if (g >= 200) check_eq("in_ready_timeout", hs.in_ready, 1);
    hs.in_valid = 1'b1;
    hs.in_data  = data;
    key_load    = kl;
    key_in      = key;
    @(posedge clk);
    #1;
    hs.in_valid = 1'b0;
    key_load    = 1'b0;
    snap_k      = key_beats_tot;
    snap_d      = dat_beats_tot;
    if (kl) model_key = key;
    if (expect_out) begin
      exp_q.push_back(des_ref(model_key, data));
      n_pushed++;
    end
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!hs.out_valid && lat < 100);
  endtask

  task automatic wait_state_wait();
    int g = 0;
    do begin @(negedge clk); g++; end while (dut_state != WAIT && g < 50);
    if (dut_state != WAIT) check_eq("reach_wait", dut_state, WAIT);
  endtask

  task automatic drain();
    logic [63:0] e;
    while (rd_idx < obs_data.size()) begin
      if (exp_q.size() == 0) begin
        check_eq("extra_beat", obs_data.size(), n_pushed);
        rd_idx = obs_data.size();
      end else begin
        e = exp_q.pop_front();
        check_eq("out_data", obs_data[rd_idx], e);
        rd_idx++;
      end
    end
  endtask

  task automatic wait_beats();
    int g = 0;
    while (obs_data.size() < n_pushed && g < 400) begin @(posedge clk); g++; end
    if (g >= 400) check_eq("beat_timeout", obs_data.size(), n_pushed);
    drain();
  endtask

  initial begin
    int lat, cnt;
    logic [63:0] d, k;
    bit kl;

    rst = 1'b1; key_in = '0; key_load = 1'b0; stub_stuck = 1'b0;
    hs.in_valid = 1'b0; hs.in_data = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_in_ready", hs.in_ready, 0);
    check_eq("rst_out_valid", hs.out_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_err", err_timeout, 0);
    check_eq("rst_out_data", hs.out_data, 0);
    check_eq("rst_wrap_outs", {des_load, des_start, des_result_sel, des_selector, des_data_bus}, 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_in_ready", hs.in_ready, 1);

    // known-answer block with a fresh key
    send_block(P1, 1'b1, K1, 1'b1);
    wait_out(lat);
    check_eq("t1_latency", lat, 12);
    check_eq("t1_kat", hs.out_data, C1);
    check_eq("t1_key_beats", key_beats_tot - snap_k, 2);
    check_eq("t1_dat_beats", dat_beats_tot - snap_d, 2);
    wait_beats();

    // same key, no reload
    send_block(64'hFEDC_BA98_7654_3210, 1'b0, '0, 1'b1);
    wait_out(lat);
    check_eq("t2_latency", lat, 10);
    check_eq("t2_key_beats", key_beats_tot - snap_k, 0);
    check_eq("t2_dat_beats", dat_beats_tot - snap_d, 2);
    wait_beats();

    // downstream back-pressure
    rdy_mode = 1;
    send_block({$urandom, $urandom}, 1'b0, '0, 1'b1);
    wait_out(lat);
    check_eq("t3_latency", lat, 10);
    repeat (20) @(negedge clk);
    check_eq("t3_in_ready_stall", hs.in_ready, 0);
    check_eq("t3_out_valid_held", hs.out_valid, 1);
    check_eq("t3_stall_stable", stall_viol, 0);
    rdy_mode = 0;
    wait_beats();
    check_eq("t3_stall_cycles", stall_cycles >= 20, 1);

    // key written during WAIT: current block keeps old key, next reloads
    send_block({$urandom, $urandom}, 1'b0, '0, 1'b1);
    wait_state_wait();
    k = {$urandom, $urandom};
    key_in = k; key_load = 1'b1;
    @(posedge clk);
    #1;
    key_load = 1'b0;
    model_key = k;
    wait_beats();
    send_block({$urandom, $urandom}, 1'b0, '0, 1'b1);
    wait_out(lat);
    check_eq("t4_latency", lat, 12);
    check_eq("t4_key_beats", key_beats_tot - snap_k, 2);
    wait_beats();

    // wrapper never ready: block dropped after the timeout
    stub_stuck = 1'b1;
    check_eq("t5_err_before", err_timeout, 0);
    send_block({$urandom, $urandom}, 1'b0, '0, 1'b0);
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
    end
    check_eq("t5_busy_cycles", cnt, 11);
    check_eq("t5_err_set", err_timeout, 1);
    check_eq("t5_no_beat", obs_data.size(), n_pushed);
    stub_stuck = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("t5_err_sticky", err_timeout, 1);

    // reset while waiting: block discarded, state and key shadow cleared
    send_block({$urandom, $urandom}, 1'b0, '0, 1'b0);
    wait_state_wait();
    rst = 1'b1;
    #1;
    check_eq("t6_busy", busy, 0);
    check_eq("t6_out_valid", hs.out_valid, 0);
    check_eq("t6_in_ready", hs.in_ready, 0);
    check_eq("t6_err_cleared", err_timeout, 0);
    check_eq("t6_out_data", hs.out_data, 0);
    check_eq("t6_wrap_outs", {des_load, des_start, des_result_sel, des_selector, des_data_bus}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_key = '0;
    repeat (12) @(negedge clk);
    check_eq("t6_no_beat", obs_data.size(), n_pushed);
    send_block({$urandom, $urandom}, 1'b1, {$urandom, $urandom}, 1'b1);
    wait_out(lat);
    check_eq("t6_latency", lat, 12);
    wait_beats();

    // randomized traffic with random back-pressure
    rdy_mode = 2;
    for (int i = 0; i < 24; i++) begin
      d  = {$urandom, $urandom};
      k  = {$urandom, $urandom};
      kl = ($urandom_range(0, 2) == 0);
      send_block(d, kl, k, 1'b1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    rdy_mode = 0;
    wait_beats();

    check_eq("final_beats", obs_data.size(), n_pushed);
    check_eq("final_q_empty", exp_q.size(), 0);
    check_eq("final_stall_stable", stall_viol, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
